row_scanout: RTL and testbench

- Display-side consumer of the double-banked row buffer that the row drawer fills.
- Generates 640x480@60 VGA timing and reads the displayed bank one pixel per clock.
- Emits registered RGB and sync signals.
- Pulses `swap` once per active line so the drawer exchanges banks and starts the next row.

---
 rtl/row_scanout_if.sv | 20 ++
 rtl/row_scanout.sv | 57 +++++
 tb/tb_row_scanout.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/row_scanout_if.sv
// row_scanout_if: row-buffer read port, bank handshake and VGA pins of the scanout block.
interface row_scanout_if;
  logic [8:0] address_read_row;
  logic [23:0] data_read_row;
  logic buf_sel;
  logic swap;
  logic [8:0] line_number;
  logic [7:0] vga_r, vga_g, vga_b;
  logic vga_hs, vga_vs, vga_de;
  modport master (
    output address_read_row, buf_sel, swap, line_number,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de,
    input data_read_row
  );
  modport slave (
    input address_read_row, buf_sel, swap, line_number,
    input vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de,
    output data_read_row
  );
endinterface

// File: rtl/row_scanout.sv
// row_scanout: VGA timing generator that scans out one row-buffer bank per line
// through a 2-clk pipeline and pulses swap before every active line.
module row_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int ROW_WIDTH = 480,
  parameter logic [23:0] BORDER = 24'h000000
) (
  input logic clk,
  input logic rst_n,
  row_scanout_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [9:0] h_cnt, v_cnt, v_next;
  logic h_last, active, in_row, hs_raw, vs_raw;
  assign h_last = h_cnt == 10'(H_TOTAL - 1);
  assign v_next = v_cnt == 10'(V_TOTAL - 1) ? 10'd0 : v_cnt + 10'd1;
  // Swap fires on the last clock of the line preceding each active line.
  assign bus.swap = h_last && v_next < 10'(V_ACTIVE);
  assign bus.address_read_row = h_cnt < 10'(ROW_WIDTH) ? h_cnt[8:0] : 9'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      bus.buf_sel <= 1'b0;
      bus.line_number <= '0;
      active <= 1'b0;
      in_row <= 1'b0;
      hs_raw <= 1'b1;
      vs_raw <= 1'b1;
      {bus.vga_r, bus.vga_g, bus.vga_b} <= '0;
      bus.vga_de <= 1'b0;
      bus.vga_hs <= 1'b1;
      bus.vga_vs <= 1'b1;
    end else begin
      h_cnt <= h_last ? 10'd0 : h_cnt + 10'd1;
      if (h_last) v_cnt <= v_next;
      bus.buf_sel <= bus.buf_sel ^ bus.swap;
      if (bus.swap) bus.line_number <= v_next[8:0];
      active <= h_cnt < 10'(H_ACTIVE) && v_cnt < 10'(V_ACTIVE);
      in_row <= h_cnt < 10'(ROW_WIDTH);
      hs_raw <= !(h_cnt >= 10'(H_ACTIVE + H_FP) && h_cnt < 10'(H_ACTIVE + H_FP + H_SYNC));
      vs_raw <= !(v_cnt >= 10'(V_ACTIVE + V_FP) && v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC));
      {bus.vga_r, bus.vga_g, bus.vga_b} <= active ? (in_row ? bus.data_read_row : BORDER) : 24'h0;
      bus.vga_de <= active;
      bus.vga_hs <= hs_raw;
      bus.vga_vs <= vs_raw;
    end
  end
endmodule

// File: tb/tb_row_scanout.sv
// tb_row_scanout: checks full-size and shrunken-timing instances against a cycle-index model.
module tb_row_scanout;
  typedef struct packed {int ha, hf, hs, hb, va, vf, vs, vb, rw; logic [23:0] border;} tp_t;
  typedef struct packed {logic de, hs, vs; logic [23:0] rgb;} pins_t;
  localparam tp_t BIG = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, rw:480, border:24'h000000};
  localparam tp_t SM = '{ha:64, hf:4, hs:8, hb:4, va:12, vf:2, vs:2, vb:3, rw:48, border:24'h3C5A96};
  localparam int SHT = 80, SFT = 1520;
  logic clk = 1'b0, rst_n = 1'b0;
  int k = 0, checks = 0, failures = 0;
  row_scanout_if big_if();
  row_scanout_if sm_if();
  row_scanout dut_big (.clk(clk), .rst_n(rst_n), .bus(big_if.master));
  row_scanout #(
    .H_ACTIVE(SM.ha), .H_FP(SM.hf), .H_SYNC(SM.hs), .H_BP(SM.hb),
    .V_ACTIVE(SM.va), .V_FP(SM.vf), .V_SYNC(SM.vs), .V_BP(SM.vb),
    .ROW_WIDTH(SM.rw), .BORDER(SM.border)
  ) dut_sm (.clk(clk), .rst_n(rst_n), .bus(sm_if.master));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    big_if.data_read_row <= {8'hAA, big_if.address_read_row[7:0], 8'h55};
    sm_if.data_read_row <= {8'hAA, sm_if.address_read_row[7:0], 8'h55};
  end
  // k = rising edges since reset release; the DUT state is a pure function of k.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) k <= 0;
    else k <= k + 1;
  function automatic int ht(tp_t t); return t.ha + t.hf + t.hs + t.hb; endfunction
  function automatic int vt(tp_t t); return t.va + t.vf + t.vs + t.vb; endfunction
  function automatic pins_t exp_pins(tp_t t, int n);
    pins_t o;
    int p, h, v;
    o = '{de:1'b0, hs:1'b1, vs:1'b1, rgb:24'h0};
    if (n < 2) return o;
    p = n - 2;
    h = p % ht(t);
    v = (p / ht(t)) % vt(t);
    o.de = h < t.ha && v < t.va;
    o.hs = !(h >= t.ha + t.hf && h < t.ha + t.hf + t.hs);
    o.vs = !(v >= t.va + t.vf && v < t.va + t.vf + t.vs);
    o.rgb = !o.de ? 24'h0 : h < t.rw ? {8'hAA, 8'(h), 8'h55} : t.border;
    return o;
  endfunction
  function automatic logic [19:0] exp_stat(tp_t t, int n);
    int h, v, c, q, r, sw, ln;
    logic s;
    h = n % ht(t);
    v = (n / ht(t)) % vt(t);
    s = h == ht(t) - 1 && (v + 1) % vt(t) < t.va;
    c = n / ht(t);
    q = c / vt(t);
    r = c % vt(t);
    sw = q * t.va + (r < t.va - 1 ? r : t.va - 1);
    ln = r < t.va ? r : t.va - 1;
    return {s, sw[0], 9'(ln), 9'(h < t.rw ? h : 0)};
  endfunction
  task automatic test_reset;
    logic [46:0] want, gb, gs;
    want = {1'b0, 1'b1, 1'b1, 24'h0, 20'h0};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      gb = {big_if.vga_de, big_if.vga_hs, big_if.vga_vs, big_if.vga_r, big_if.vga_g, big_if.vga_b,
            big_if.swap, big_if.buf_sel, big_if.line_number, big_if.address_read_row};
      gs = {sm_if.vga_de, sm_if.vga_hs, sm_if.vga_vs, sm_if.vga_r, sm_if.vga_g, sm_if.vga_b,
            sm_if.swap, sm_if.buf_sel, sm_if.line_number, sm_if.address_read_row};
      checks += 2;
      if (gb !== want) begin failures++; $display("FAIL reset_big pass=%0d got=%h exp=%h", i, gb, want); end
      if (gs !== want) begin failures++; $display("FAIL reset_sm pass=%0d got=%h exp=%h", i, gs, want); end
      repeat (5) @(negedge clk);
    end
    rst_n = 1'b1;
  endtask
  task automatic test_line_timing;
    int falls[$];
    int lows = 0, des = 0, de_rise = -1, de_fall = -1;
    logic phs = 1'b1, pde = 1'b0;
    while (k < 1700) begin
      @(negedge clk);
      if (!big_if.vga_hs && phs) falls.push_back(k);
      if (!big_if.vga_hs) lows++;
      if (big_if.vga_de && k <= 1601) des++;
      if (big_if.vga_de && !pde && de_rise < 0) de_rise = k;
      if (!big_if.vga_de && pde && de_fall < 0) de_fall = k;
      phs = big_if.vga_hs;
      pde = big_if.vga_de;
    end
    checks += 5;
    if (falls.size() != 2 || falls[0] != 658)
      begin failures++; $display("FAIL hs_first_fall got=%0d n=%0d exp=658 n=2", falls[0], falls.size()); end
    if (falls[1] - falls[0] != 800)
      begin failures++; $display("FAIL hs_period got=%0d exp=800", falls[1] - falls[0]); end
    if (lows != 192) begin failures++; $display("FAIL hs_low_clks got=%0d exp=192", lows); end
    if (de_rise != 2 || de_fall - de_rise != 640)
      begin failures++; $display("FAIL de_run got rise=%0d len=%0d exp rise=2 len=640", de_rise, de_fall - de_rise); end
    if (des != 1280) begin failures++; $display("FAIL de_two_lines got=%0d exp=1280", des); end
  endtask
  task automatic test_frame;
    int k0, sw = 0, tg = 0, bad = 0, vlow = 0, vfall = -1;
    logic pb, pv;
    while (k % SFT != 0) @(negedge clk);
    k0 = k;
    pb = sm_if.buf_sel;
    pv = sm_if.vga_vs;
    while (k < k0 + SFT) begin
      @(negedge clk);
      if (sm_if.swap) begin
        sw++;
        if ((k - k0) / SHT >= SM.va && (k - k0) / SHT <= 17) bad++;
      end
      if (sm_if.buf_sel != pb) tg++;
      if (!sm_if.vga_vs) vlow++;
      if (!sm_if.vga_vs && pv && vfall < 0) vfall = k - k0;
      pb = sm_if.buf_sel;
      pv = sm_if.vga_vs;
    end
    checks += 6;
    if (sw != 12) begin failures++; $display("FAIL frame_swaps got=%0d exp=12", sw); end
    if (tg != 12) begin failures++; $display("FAIL frame_toggles got=%0d exp=12", tg); end
    if (bad != 0) begin failures++; $display("FAIL blank_swaps got=%0d exp=0", bad); end
    if (sm_if.buf_sel !== 1'b0) begin failures++; $display("FAIL frame_end_bank got=%b exp=0", sm_if.buf_sel); end
    if (vlow != 160) begin failures++; $display("FAIL vs_low_clks got=%0d exp=160", vlow); end
    if (vfall != 1122) begin failures++; $display("FAIL vs_fall got=%0d exp=1122", vfall); end
  endtask
  task automatic test_swap_alignment;
    logic pb;
    while (k % SFT != SFT - 1) @(negedge clk);
    pb = sm_if.buf_sel;
    checks++;
    if (sm_if.swap !== 1'b1) begin failures++; $display("FAIL swap_last_line got=%b exp=1", sm_if.swap); end
    @(negedge clk);
    checks += 2;
    if (sm_if.line_number !== 9'd0) begin failures++; $display("FAIL line0_number got=%0d exp=0", sm_if.line_number); end
    if (sm_if.buf_sel !== ~pb) begin failures++; $display("FAIL line0_bank got=%b exp=%b", sm_if.buf_sel, ~pb); end
    while (k % SFT != 11 * SHT - 1) @(negedge clk);
    checks++;
    if (sm_if.swap !== 1'b1) begin failures++; $display("FAIL swap_before_last got=%b exp=1", sm_if.swap); end
    @(negedge clk);
    checks++;
    if (sm_if.line_number !== 9'd11) begin failures++; $display("FAIL last_line_number got=%0d exp=11", sm_if.line_number); end
    while (k % SFT != 12 * SHT - 1) @(negedge clk);
    checks += 2;
    if (sm_if.swap !== 1'b0) begin failures++; $display("FAIL swap_into_blank got=%b exp=0", sm_if.swap); end
    if (sm_if.line_number !== 9'd11) begin failures++; $display("FAIL blank_number got=%0d exp=11", sm_if.line_number); end
  endtask
  task automatic test_pixel_path(input int n);
    pins_t pb, ps;
    logic [19:0] sb, ss;
    repeat (n) begin
      @(negedge clk);
      pb = {big_if.vga_de, big_if.vga_hs, big_if.vga_vs, big_if.vga_r, big_if.vga_g, big_if.vga_b};
      ps = {sm_if.vga_de, sm_if.vga_hs, sm_if.vga_vs, sm_if.vga_r, sm_if.vga_g, sm_if.vga_b};
      sb = {big_if.swap, big_if.buf_sel, big_if.line_number, big_if.address_read_row};
      ss = {sm_if.swap, sm_if.buf_sel, sm_if.line_number, sm_if.address_read_row};
      checks += 4;
      if (pb !== exp_pins(BIG, k)) begin failures++; $display("FAIL pins_big k=%0d got=%h exp=%h", k, pb, exp_pins(BIG, k)); end
      if (ps !== exp_pins(SM, k)) begin failures++; $display("FAIL pins_sm k=%0d got=%h exp=%h", k, ps, exp_pins(SM, k)); end
      if (sb !== exp_stat(BIG, k)) begin failures++; $display("FAIL stat_big k=%0d got=%h exp=%h", k, sb, exp_stat(BIG, k)); end
      if (ss !== exp_stat(SM, k)) begin failures++; $display("FAIL stat_sm k=%0d got=%h exp=%h", k, ss, exp_stat(SM, k)); end
    end
  endtask
  task automatic test_reset_midframe;
    while (k % SFT != 7 * SHT + 30) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sm_if.line_number !== 9'd0 || sm_if.buf_sel !== 1'b0 || sm_if.vga_de !== 1'b0)
      begin failures++; $display("FAIL midframe_reset got ln=%0d bank=%b de=%b exp 0 0 0",
                                 sm_if.line_number, sm_if.buf_sel, sm_if.vga_de); end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    while (k < SHT) begin
      @(negedge clk);
      checks++;
      if (sm_if.swap !== (k == SHT - 1) || sm_if.buf_sel !== (k >= SHT))
        begin failures++; $display("FAIL restart_swap k=%0d got swap=%b bank=%b", k, sm_if.swap, sm_if.buf_sel); end
    end
  endtask
  initial begin
    test_reset;
    test_line_timing;
    test_frame;
    test_swap_alignment;
    test_pixel_path(1000 + int'($urandom_range(0, 1500)));
    test_reset_midframe;
    test_pixel_path(1700);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
